// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO stream front-ends (write and read side).
package cdc_fifo_pkg;

  // Usable words for a pointer with MSB ptr_msb. One slot is always kept empty
  // so that a full FIFO can be told apart from an empty one.
  function automatic logic [31:0] f_capacity(input int unsigned ptr_msb);
    return (32'd1 << (ptr_msb + 1)) - 32'd1;
  endfunction

  // Distance from b forward to a. The caller keeps only the pointer-width LSBs,
  // which gives the result modulo 2^width.
  function automatic logic [31:0] f_ptr_dist(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry valid/ready skid register. The main entry is the head. The skid
// entry catches a word that arrives while the head is stalled. up_ready is a
// flop output, so there is no combinational path from dn_ready to up_ready.
module wr_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          main_valid, skid_valid;
  logic [DW-1:0] main_data, skid_data;
  logic          accept, pop;

  assign up_ready = !skid_valid;
  assign accept   = up_valid & up_ready;
  assign pop      = main_valid & dn_ready;
  assign dn_valid = main_valid;
  assign dn_data  = main_data;

  // Head/skid bookkeeping. The skid entry fills only when a word arrives while
  // the head cannot leave. It drains into the head on the next pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (pop) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid && !pop) begin
        skid_data  <= up_data;
        skid_valid <= 1'b1;
      end else begin
        main_data  <= up_data;
        main_valid <= 1'b1;
      end
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wr_stream_if.sv
// Write-side stream front-end for the dual-clock FIFO. It converts a valid/ready
// stream into write-controller increments and RAM writes. It also publishes a
// registered fill level and an almost-full flag.
// Optional feature: define WR_STREAM_IF_SKID_EN for a registered-ready two-entry
// skid buffer. Without it the stream passes straight through.
module wr_stream_if
  import cdc_fifo_pkg::*;
#(
  parameter int P_PTR_MSB      = 4,
  parameter int P_DATA_MSB     = 31,
  parameter int P_AFULL_THRESH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [P_DATA_MSB:0] i_data,
  input  logic [P_PTR_MSB:0]  i_wr_ptr,
  input  logic [P_PTR_MSB:0]  i_rd_ptr,
  output logic                o_inc,
  output logic                o_wr_en,
  output logic [P_PTR_MSB:0]  o_wr_addr,
  output logic [P_DATA_MSB:0] o_wr_data,
  output logic [P_PTR_MSB:0]  o_level,
  output logic                o_afull
);

  localparam int                 PW      = P_PTR_MSB + 1;
  localparam logic [31:0]        CAP     = f_capacity(P_PTR_MSB);
  localparam logic [P_PTR_MSB:0] PTR_ONE = {{P_PTR_MSB{1'b0}}, 1'b1};

  logic                r_init;
  logic                w_space;
  logic                head_valid;
  logic [P_DATA_MSB:0] head_data;
  logic [P_PTR_MSB:0]  level_next;
  logic                afull_next;

  // Exact complement of the write controller's full test, so no increment is dropped.
  assign w_space = (i_wr_ptr + PTR_ONE) != i_rd_ptr;

`ifdef WR_STREAM_IF_SKID_EN
  logic skid_ready;

  wr_skid_buf #(.DW(P_DATA_MSB + 1)) u_skid (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .up_valid (i_valid & r_init),
    .up_ready (skid_ready),
    .up_data  (i_data),
    .dn_valid (head_valid),
    .dn_ready (w_space),
    .dn_data  (head_data)
  );

  assign o_ready   = r_init & skid_ready;
  assign o_wr_data = head_data;
`else
  // Pass-through: a word commits in the same cycle it is accepted.
  assign head_valid = i_valid & r_init;
  assign head_data  = i_data;
  assign o_ready    = r_init & w_space;
  assign o_wr_data  = r_init ? head_data : '0;
`endif

  assign o_inc     = head_valid & w_space;
  assign o_wr_en   = o_inc;
  assign o_wr_addr = i_wr_ptr;

  // Next-cycle occupancy and almost-full. Occupancy never exceeds CAP, so the subtraction cannot wrap.
  always_comb begin
    level_next = PW'(f_ptr_dist(32'(i_wr_ptr), 32'(i_rd_ptr)));
    afull_next = (CAP - 32'(level_next)) <= 32'(P_AFULL_THRESH);
  end

  // r_init holds off o_ready for the first edge after reset. Level and almost-full are registered each cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init  <= 1'b0;
      o_level <= '0;
      o_afull <= 1'b0;
    end else begin
      r_init  <= 1'b1;
      o_level <= level_next;
      o_afull <= afull_next;
    end
  end

endmodule

// File: tb/tb_wr_stream_if.sv
// Self-checking bench for wr_stream_if (works with or without WR_STREAM_IF_SKID_EN).
module tb_wr_stream_if;
  localparam int PM = 4, DM = 31, TH = 4, PW = 5, CAP = 31;

  logic clk = 0, rst_n = 0, valid = 0;
  logic ready, inc, wr_en, afull;
  logic [DM:0] data = '0, wr_data;
  logic [PW-1:0] wr_ptr = '0, rd_ptr = '0, wr_addr, level;

  always #5 clk = ~clk;

  wr_stream_if #(.P_PTR_MSB(PM), .P_DATA_MSB(DM), .P_AFULL_THRESH(TH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_wr_ptr(wr_ptr), .i_rd_ptr(rd_ptr), .o_inc(inc), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_level(level), .o_afull(afull));

  int errs = 0, checks = 0;
  logic [31:0] q[$];            // accepted but not yet committed words
  logic [31:0] commit_data[$];
  logic [PW-1:0] commit_addr[$];
  int since = 0, mode = 0, limit = 0, n_acc = 0;
  bit reader = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle. The bench acts as the write controller (wr_ptr follows o_inc),
  // an optional reader, and the producer. It scoreboards every accept and commit.
  task automatic tick();
    logic [PW-1:0] wp, rp, wn;
    logic s_inc, acc;
    logic [31:0] d;
    @(negedge clk);
    wp = wr_ptr; rp = rd_ptr; wn = wp + 1'b1;
    s_inc = inc; acc = valid & ready;
    chk("wr_en_eq_inc", wr_en, inc);
`ifdef WR_STREAM_IF_SKID_EN
    chk("ready", ready, (since >= 1 && q.size() < 2));
`else
    chk("ready", ready, (since >= 1 && wn != rp));
`endif
    if (acc) q.push_back(data);
    if (s_inc) begin
      chk("commit_not_full", wn != rp, 1);
      chk("commit_addr", wr_addr, wp);
      chk("commit_pending", q.size() != 0, 1);
      if (q.size() != 0) begin
        d = q.pop_front();
        chk("commit_data", wr_data, d);
      end
      commit_data.push_back(wr_data);
      commit_addr.push_back(wp);
    end
    @(posedge clk); #1;
    since++;
    chk("level", level, 32'(PW'(wp - rp)));
    chk("afull", afull, (CAP - int'(PW'(wp - rp))) <= TH);
    if (s_inc) wr_ptr = wr_ptr + 1'b1;
    if (reader && rd_ptr != wr_ptr && $urandom_range(0, 1) == 1) rd_ptr = rd_ptr + 1'b1;
    if (acc) n_acc++;
    if (acc || !valid) begin
      case (mode)
        1: begin if (acc) data = data + 1; valid = (n_acc < limit); end
        2: begin data = $urandom; valid = ($urandom_range(0, 3) != 0); end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    valid = 0; mode = 0; reader = 0;
    @(posedge clk); #1;
    rst_n = 0; wr_ptr = wp; rd_ptr = rp;
    q.delete(); commit_data.delete(); commit_addr.delete();
    since = 0; n_acc = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  typedef struct { logic [PW-1:0] wp, rp; logic space; logic [PW-1:0] lvl; logic af; } vec_t;
  vec_t tbl[11];
  logic [PW-1:0] wrap_exp[5];
  logic [PW-1:0] r;
  int n0;

  initial begin
    tbl[0]  = '{5'd0,  5'd0,  1'b1, 5'd0,  1'b0};
    tbl[1]  = '{5'd30, 5'd0,  1'b1, 5'd30, 1'b1};
    tbl[2]  = '{5'd31, 5'd0,  1'b0, 5'd31, 1'b1};
    tbl[3]  = '{5'd26, 5'd0,  1'b1, 5'd26, 1'b0};
    tbl[4]  = '{5'd27, 5'd0,  1'b1, 5'd27, 1'b1};
    tbl[5]  = '{5'd2,  5'd30, 1'b1, 5'd4,  1'b0};
    tbl[6]  = '{5'd29, 5'd30, 1'b0, 5'd31, 1'b1};
    tbl[7]  = '{5'd5,  5'd6,  1'b0, 5'd31, 1'b1};
    tbl[8]  = '{5'd0,  5'd1,  1'b0, 5'd31, 1'b1};
    tbl[9]  = '{5'd15, 5'd15, 1'b1, 5'd0,  1'b0};
    tbl[10] = '{5'd3,  5'd31, 1'b1, 5'd4,  1'b0};
    wrap_exp = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2};

    // Values while reset is held
    rst_n = 0; valid = 1; data = 32'h1234_5678; wr_ptr = 9; rd_ptr = 3;
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_inc", inc, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 9);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);

    // Level / almost-full / space table
    do_reset(0, 0);
    tick();
    foreach (tbl[i]) begin
      wr_ptr = tbl[i].wp; rd_ptr = tbl[i].rp;
      tick();
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_afull", afull, tbl[i].af);
`ifdef WR_STREAM_IF_SKID_EN
      chk("tbl_ready", ready, 1);
`else
      chk("tbl_ready", ready, tbl[i].space);
`endif
    end

    // Fill from empty: 31 words at addresses 0..30, then stall
    do_reset(0, 0);
    data = 32'h100; limit = 40; mode = 1; valid = 1;
    repeat (36) tick();
    chk("fill_count", commit_addr.size(), 31);
    foreach (commit_addr[i]) chk("fill_addr", commit_addr[i], i);
    chk("fill_wr_ptr", wr_ptr, 31);
    chk("fill_level", level, 31);
    chk("fill_afull", afull, 1);

    // Full, then one read frees exactly one slot
    n0 = commit_addr.size();
    repeat (3) tick();
    chk("full_no_commit", commit_addr.size(), n0);
    rd_ptr = 1;
    repeat (3) tick();
    chk("free1_count", commit_addr.size(), n0 + 1);
    if (commit_addr.size() > n0) chk("free1_addr", commit_addr[n0], 31);

    // Pointer wrap
    do_reset(30, 30);
    data = 32'h300; limit = 5; mode = 1; valid = 1;
    repeat (10) tick();
    chk("wrap_count", commit_addr.size(), 5);
    foreach (wrap_exp[i]) if (i < commit_addr.size()) chk("wrap_addr", commit_addr[i], wrap_exp[i]);
    chk("wrap_level", level, 5);

`ifndef WR_STREAM_IF_SKID_EN
    // Pass-through: commit in the accept cycle
    do_reset(7, 0);
    tick();
    valid = 1; data = 32'h55;
    #1;
    chk("pt_wr_en", wr_en, 1);
    chk("pt_wr_addr", wr_addr, 7);
    chk("pt_wr_data", wr_data, 32'h55);
    tick();
    valid = 0;
    tick();
`else
    // Skid build: space pattern 1,0,0,1 while streaming A0..A3
    do_reset(0, 0);
    tick();
    data = 32'hA0; limit = 4; mode = 1; valid = 1;
    for (int i = 0; i < 10; i++) begin
      rd_ptr = (i == 1 || i == 2) ? wr_ptr + 1'b1 : wr_ptr;
      tick();
    end
    chk("skid_count", commit_data.size(), 4);
    foreach (commit_data[i]) chk("skid_data", commit_data[i], 32'hA0 + i);
`endif

    // Reset while words are buffered (0xBEEF in the skid entry when enabled)
    do_reset(0, 0);
    tick();
    rd_ptr = 1;
    valid = 1; data = 32'h1234;
    tick();
    data = 32'hBEEF;
    tick();
    valid = 0;
    rst_n = 0; rd_ptr = 0;
    #1;
    chk("midrst_inc", inc, 0);
    chk("midrst_ready", ready, 0);
    q.delete(); commit_data.delete(); commit_addr.delete(); since = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (5) tick();
    chk("midrst_no_commit", commit_data.size(), 0);

    // Random traffic with a random reader
    r = PW'($urandom_range(0, 31));
    do_reset(r, r);
    mode = 2; reader = 1; data = $urandom; valid = 1;
    repeat (500) tick();
    mode = 0; valid = 0;
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
